wolverine_mc_model: RTL
=======================

Name: wolverine_mc_model

Overview:
- Synthesizable, parametrised Wolverine memory-controller model.
- Replaces the per-tick software memory service for the MC request/response channels.
- Serves NUM_CH independent AE memory ports against one shared on-chip word array. Each port has fixed request-to-response latency, bounded outstanding requests with stall back-pressure, response back-pressure and flush handshakes.
- Sits in the Wolverine test harness between the accelerator's mcReq*/mcRes* ports and nothing else; no host callback needed per cycle.

Parameters:
- NUM_CH, 2, number of independent MC ports (1..16)
- LATENCY, 4, cycles from request acceptance to earliest response valid (>=1)
- DEPTH, 8, max outstanding requests per channel, in-flight plus queued (power of 2, >= 2)
- MEM_AW, 12, log2 of backing-store size in 64-bit words
- RTNCTL_W, 32, return-control tag width

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mc_req_valid  in  NUM_CH  request valid per channel
- mc_req_cmd  in  3*NUM_CH  request command, packed, channel 0 in LSBs (same packing for all vectors)
- mc_req_scmd  in  4*NUM_CH  sub-command, ignored except echoed
- mc_req_size  in  2*NUM_CH  log2 bytes (0=1B .. 3=8B)
- mc_req_addr  in  48*NUM_CH  byte address
- mc_req_data  in  64*NUM_CH  write data, lane-aligned to addr[2:0]
- mc_req_rtnctl  in  RTNCTL_W*NUM_CH  tag returned with the response
- mc_req_stall  out  NUM_CH  channel cannot accept
- mc_res_valid  out  NUM_CH  response valid
- mc_res_cmd  out  3*NUM_CH  response command
- mc_res_scmd  out  4*NUM_CH  echoed scmd
- mc_res_data  out  64*NUM_CH  read data, full word
- mc_res_rtnctl  out  RTNCTL_W*NUM_CH  echoed tag
- mc_res_stall  in  NUM_CH  AE refuses responses
- mc_req_flush  in  NUM_CH  flush request
- mc_res_flush_ok  out  NUM_CH  flush complete pulse
- err_cmd  out  NUM_CH  sticky: unsupported cmd seen

Behaviour:
- Reset: all outputs 0, all occupancy counters 0, pipelines and FIFOs empty, flush state IDLE. The memory array is not cleared.
- Request acceptance:
  - accept = mc_req_valid & ~mc_req_stall, per channel.
  - mc_req_stall = (occ == DEPTH). It is a function of registers only.
  - occ = inflight + fifo count. occ increments on accept and decrements on response issue; both in the same cycle leaves occ unchanged.
- Commands:
  - cmd 1 RD: read word addr[MEM_AW+2:3] at acceptance → response cmd 2 (RD_DATA) with the full 64-bit word.
  - cmd 2 WR: at the acceptance edge, write bytes selected by size/addr[2:0] (size 3 ignores addr[2:0]) → response cmd 3 (WR_CMP), data 0.
  - Other cmds: no memory action; err_cmd[ch] set sticky; response cmd 0 still returned so tags are not lost.
- Address: bits above MEM_AW+2 are ignored (wrap modulo array size).
- Same-cycle ordering:
  - Reads see memory state before that cycle's writes.
  - Multiple writes to the same word in one cycle merge per byte; the highest channel index wins per byte.
- Response pipeline:
  - Accepted requests traverse a LATENCY-1 stage shift pipeline into a per-channel response FIFO of DEPTH entries.
  - In any cycle where FIFO is non-empty and mc_res_stall is low, pop the head and register it onto mc_res_* with mc_res_valid=1 for exactly one cycle; otherwise mc_res_valid=0.
  - Accept at edge t with empty path and res_stall low → mc_res_valid high in cycle t+LATENCY.
  - Responses on one channel are in acceptance order.
  - FIFO cannot overflow, guaranteed by occ ≤ DEPTH.
- Flush FSM, per channel:
  - IDLE: mc_req_flush=1 → WAIT.
  - WAIT: occ==0 → pulse mc_res_flush_ok for 1 cycle → IDLE.
  - Flush while occ==0 → flush_ok the cycle after the flush is sampled.
  - New requests accepted during WAIT count toward occ.
- Reset mid-operation drops all outstanding responses; no flush_ok is issued.

Decomposition:
- Package wolverine_mc_pkg holds:
  - MC_CMD_RD=1, MC_CMD_WR=2, MC_RES_RD_DATA=2, MC_RES_WR_CMP=3
  - response struct {cmd, scmd, data, rtnctl}
  - byte-enable function (size, addr[2:0]) → 8-bit mask
- Sub-module wolverine_mc_chan, one per channel: latency pipeline, response FIFO, occ counter, stall, flush FSM. The top level holds the shared memory array and cross-channel write merge.

Test Plan:
- Ch0: WR addr 0x40, size 3, data 0xDEADBEEF_01234567, rtnctl 5 → WR_CMP rtnctl 5 at t+4. Then RD 0x40 rtnctl 6 → RD_DATA 0xDEADBEEF_01234567.
- Ch1: WR addr 0x43, size 0, data 0xAB<<24 over a word of zeros → RD 0x40 returns 0x00000000_AB000000.
- Ch0: hold res_stall=1, issue 8 reads → stall rises after the 8th accept; no res_valid. Release → 8 responses in rtnctl order, one per cycle; stall drops.
- Ch0 and ch1 WR same word, same cycle, data 0x11…/0x22… → subsequent RD returns 0x22…; a same-cycle RD of that word returns the old value.
- Ch0: 3 writes outstanding then flush → flush_ok one cycle after last WR_CMP issued. Flush with nothing outstanding → flush_ok next cycle.
- Ch0: cmd 7 → err_cmd[0]=1, response cmd 0 with echoed tag. Reset mid-burst → all outputs 0 next cycle; stall=0.

Source files
------------

// File: rtl/wolverine_mc_pkg.sv
// Shared command codes, response record and byte-lane helper for the Wolverine MC model.
package wolverine_mc_pkg;

    localparam logic [2:0] MC_CMD_RD      = 3'd1;
    localparam logic [2:0] MC_CMD_WR      = 3'd2;
    localparam logic [2:0] MC_RES_RD_DATA = 3'd2;
    localparam logic [2:0] MC_RES_WR_CMP  = 3'd3;

    // Tag field is sized for the widest supported rtnctl; narrower tags zero-extend.
    localparam int MC_RTNCTL_MAX_W = 64;

    typedef struct packed {
        logic [2:0]                 cmd;
        logic [3:0]                 scmd;
        logic [63:0]                data;
        logic [MC_RTNCTL_MAX_W-1:0] rtnctl;
    } mc_res_t;

    typedef enum logic {
        FL_IDLE = 1'b0,
        FL_WAIT = 1'b1
    } flush_state_e;

    // Sub-word accesses are aligned down to their natural size.
    function automatic logic [7:0] mc_byte_en(input logic [1:0] size, input logic [2:0] lo);
        logic [7:0] be;
        case (size)
            2'd0:    be = 8'h01 << lo;
            2'd1:    be = 8'h03 << {lo[2:1], 1'b0};
            2'd2:    be = 8'h0F << {lo[2], 2'b00};
            default: be = 8'hFF;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/wolverine_mc_chan.sv
// One MC port: fixed-latency pipeline, response FIFO, occupancy/stall and flush handshake.
module wolverine_mc_chan
    import wolverine_mc_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    req_valid,
    input  logic    req_bad,
    input  mc_res_t req_ent,
    output logic    req_stall,
    output logic    req_accept,
    input  logic    res_stall,
    output logic    res_valid,
    output mc_res_t res_ent,
    input  logic    flush,
    output logic    flush_ok,
    output logic    err_cmd
);
    localparam int PW     = $clog2(DEPTH);
    localparam int STAGES = LATENCY - 1;
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    logic [PW:0]   occ_q, occ_d, cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    mc_res_t       fifo_q [DEPTH];
    logic          tail_vld;
    mc_res_t       tail_ent;
    logic          pop;
    logic          res_valid_q, res_valid_d;
    mc_res_t       res_ent_q, res_ent_d;
    logic          err_q, err_d;
    flush_state_e  fl_q, fl_d;

    assign req_stall  = (occ_q == DEPTH_C);
    assign req_accept = req_valid & ~req_stall & ~reset;

    if (STAGES == 0) begin : g_nopipe
        assign tail_vld = req_accept;
        assign tail_ent = req_ent;
    end else begin : g_pipe
        logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;
        mc_res_t           ent_pipe_q [STAGES];
        mc_res_t           ent_pipe_d [STAGES];

        always_comb begin
            vld_pipe_d[0] = req_accept;
            ent_pipe_d[0] = req_ent;
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
                ent_pipe_d[i] = ent_pipe_q[i-1];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) vld_pipe_q <= '0;
            else       vld_pipe_q <= vld_pipe_d;
            ent_pipe_q <= ent_pipe_d;
        end

        assign tail_vld = vld_pipe_q[STAGES-1];
        assign tail_ent = ent_pipe_q[STAGES-1];
    end

    always_comb begin
        pop         = (cnt_q != '0) & ~res_stall;
        wr_ptr_d    = tail_vld ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d       = cnt_q;
        occ_d       = occ_q;
        if (tail_vld && !pop)      cnt_d = cnt_q + (PW+1)'(1);
        else if (!tail_vld && pop) cnt_d = cnt_q - (PW+1)'(1);
        if (req_accept && !pop)      occ_d = occ_q + (PW+1)'(1);
        else if (!req_accept && pop) occ_d = occ_q - (PW+1)'(1);
        res_valid_d = pop;
        res_ent_d   = pop ? fifo_q[rd_ptr_q] : '0;
        err_d       = err_q | (req_accept & req_bad);
    end

    // flush_ok is a Moore output so it is high in the first cycle WAIT sees an empty channel.
    always_comb begin
        fl_d     = fl_q;
        flush_ok = 1'b0;
        case (fl_q)
            FL_IDLE: if (flush) fl_d = FL_WAIT;
            FL_WAIT: if (occ_q == '0) begin
                flush_ok = 1'b1;
                fl_d     = FL_IDLE;
            end
            default: fl_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_ent_q   <= '0;
            err_q       <= 1'b0;
            fl_q        <= FL_IDLE;
        end else begin
            occ_q       <= occ_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            res_valid_q <= res_valid_d;
            res_ent_q   <= res_ent_d;
            err_q       <= err_d;
            fl_q        <= fl_d;
        end
    end

    always_ff @(posedge clock) begin
        if (tail_vld) fifo_q[wr_ptr_q] <= tail_ent;
    end

    assign res_valid = res_valid_q;
    assign res_ent   = res_ent_q;
    assign err_cmd   = err_q;

endmodule

// File: rtl/wolverine_mc.sv
// Wolverine MC model top: shared word array, cross-channel write merge, per-port channel engines.
module wolverine_mc_model
    import wolverine_mc_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int LATENCY  = 4,
    parameter int DEPTH    = 8,
    parameter int MEM_AW   = 12,
    parameter int RTNCTL_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            mc_req_valid,
    input  logic [3*NUM_CH-1:0]          mc_req_cmd,
    input  logic [4*NUM_CH-1:0]          mc_req_scmd,
    input  logic [2*NUM_CH-1:0]          mc_req_size,
    input  logic [48*NUM_CH-1:0]         mc_req_addr,
    input  logic [64*NUM_CH-1:0]         mc_req_data,
    input  logic [RTNCTL_W*NUM_CH-1:0]   mc_req_rtnctl,
    output logic [NUM_CH-1:0]            mc_req_stall,
    output logic [NUM_CH-1:0]            mc_res_valid,
    output logic [3*NUM_CH-1:0]          mc_res_cmd,
    output logic [4*NUM_CH-1:0]          mc_res_scmd,
    output logic [64*NUM_CH-1:0]         mc_res_data,
    output logic [RTNCTL_W*NUM_CH-1:0]   mc_res_rtnctl,
    input  logic [NUM_CH-1:0]            mc_res_stall,
    input  logic [NUM_CH-1:0]            mc_req_flush,
    output logic [NUM_CH-1:0]            mc_res_flush_ok,
    output logic [NUM_CH-1:0]            err_cmd
);
    logic [63:0] mem [2**MEM_AW];

    logic [NUM_CH-1:0]              accept;
    logic [NUM_CH-1:0]              is_wr;
    logic [NUM_CH-1:0][MEM_AW-1:0]  widx;
    logic [NUM_CH-1:0][7:0]         wbe;
    logic [NUM_CH-1:0][63:0]        wdata;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [2:0]        cmd;
        logic [MEM_AW-1:0] idx;
        logic              bad;
        mc_res_t           req_ent, res_ent;

        assign cmd       = mc_req_cmd[ch*3 +: 3];
        assign idx       = mc_req_addr[ch*48+3 +: MEM_AW];
        assign bad       = (cmd != MC_CMD_RD) && (cmd != MC_CMD_WR);
        assign is_wr[ch] = (cmd == MC_CMD_WR);
        assign widx[ch]  = idx;
        assign wbe[ch]   = mc_byte_en(mc_req_size[ch*2 +: 2], mc_req_addr[ch*48 +: 3]);
        assign wdata[ch] = mc_req_data[ch*64 +: 64];

        // Read data is captured from the pre-edge array, so same-cycle writes are not visible.
        always_comb begin
            req_ent        = '0;
            req_ent.scmd   = mc_req_scmd[ch*4 +: 4];
            req_ent.rtnctl = MC_RTNCTL_MAX_W'(mc_req_rtnctl[ch*RTNCTL_W +: RTNCTL_W]);
            case (cmd)
                MC_CMD_RD: begin
                    req_ent.cmd  = MC_RES_RD_DATA;
                    req_ent.data = mem[idx];
                end
                MC_CMD_WR: req_ent.cmd = MC_RES_WR_CMP;
                default:   req_ent.cmd = 3'd0;
            endcase
        end

        wolverine_mc_chan #(.LATENCY(LATENCY), .DEPTH(DEPTH)) u_chan (
            .clock      (clock),
            .reset      (reset),
            .req_valid  (mc_req_valid[ch]),
            .req_bad    (bad),
            .req_ent    (req_ent),
            .req_stall  (mc_req_stall[ch]),
            .req_accept (accept[ch]),
            .res_stall  (mc_res_stall[ch]),
            .res_valid  (mc_res_valid[ch]),
            .res_ent    (res_ent),
            .flush      (mc_req_flush[ch]),
            .flush_ok   (mc_res_flush_ok[ch]),
            .err_cmd    (err_cmd[ch])
        );

        assign mc_res_cmd[ch*3 +: 3]                  = res_ent.cmd;
        assign mc_res_scmd[ch*4 +: 4]                 = res_ent.scmd;
        assign mc_res_data[ch*64 +: 64]               = res_ent.data;
        assign mc_res_rtnctl[ch*RTNCTL_W +: RTNCTL_W] = res_ent.rtnctl[RTNCTL_W-1:0];
    end

    // Later channels overwrite earlier ones byte by byte within the same edge.
    always_ff @(posedge clock) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (accept[ch] && is_wr[ch]) begin
                for (int b = 0; b < 8; b++) begin
                    if (wbe[ch][b]) mem[widx[ch]][b*8 +: 8] <= wdata[ch][b*8 +: 8];
                end
            end
        end
    end

endmodule
